cia_timer_a: RTL and testbench

CIA_TIMER_A -- requirements
Module: cia_timer_a

---
 rtl/cia_timer_a_if.sv | 21 ++
 rtl/cia_timer_a.sv | 112 +++++++++++
 tb/tb_cia_timer_a.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cia_timer_a_if.sv
// CIA timer A register bus: write strobe, register selects, write/read data.
// Latency: writes take effect on the next clk7_en-qualified clk edge; reads are combinational.
// Backpressure: none; the bus is always ready and every access completes in one enabled cycle.
interface cia_timer_a_if;
    logic       wr;        // 1 = write, 0 = read
    logic       tlo;       // timer low byte select
    logic       thi;       // timer high byte select
    logic       tcr;       // control register select
    logic [7:0] data_in;   // write data
    logic [7:0] data_out;  // read data

    modport master (
        output wr, tlo, thi, tcr, data_in,
        input  data_out
    );

    modport slave (
        input  wr, tlo, thi, tcr, data_in,
        output data_out
    );
endinterface

// File: rtl/cia_timer_a.sv
// CIA timer A: 16-bit reloadable down counter with latch, control register and underflow pulse.
// Latency: register writes and counting land on the next clk7_en edge; tmr_ovf rises one enabled cycle after underflow.
// Backpressure: none; bus accesses always complete, reads are combinational and side-effect free.
//
// Ports: clk / reset_n (async active-low), clk7_en (global clock enable), eclk (count tick),
//        bus (register access, slave side), tmr_ovf (underflow pulse), spmode (CR bit 6).
module cia_timer_a (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk7_en,
    input  logic          eclk,
    cia_timer_a_if.slave  bus,
    output logic          tmr_ovf,
    output logic          spmode
);

    logic [15:0] latch;
    logic [15:0] counter;
    logic        start;
    logic        runmode;
    logic        inmode;
    logic        spmode_bit;

    logic [15:0] latch_nxt;
    logic [15:0] counter_nxt;
    logic        start_nxt;

    logic wr_en;
    logic wr_tlo;
    logic wr_thi;
    logic wr_tcr;
    logic tick;
    logic underflow;
    logic force_load;

    assign wr_en      = clk7_en & bus.wr;
    assign wr_tlo     = wr_en & bus.tlo;
    assign wr_thi     = wr_en & bus.thi;
    assign wr_tcr     = wr_en & bus.tcr;
    assign tick       = clk7_en & eclk & start;
    assign underflow  = tick & (counter == 16'h0000);
    // CR bit 4 is a strobe: it acts on the counter and is never stored.
    assign force_load = wr_tcr & bus.data_in[4];

    // Latch is resolved first so a reload in the same cycle as a high-byte
    // write picks up the freshly written byte.
    always_comb begin
        latch_nxt = latch;
        if (wr_tlo) latch_nxt[7:0]  = bus.data_in;
        if (wr_thi) latch_nxt[15:8] = bus.data_in;
    end

    // Reload (underflow or forced) has priority over decrement, so 0000
    // never wraps to FFFF. A stopped timer follows high-byte writes directly.
    always_comb begin
        counter_nxt = counter;
        if (underflow || force_load)
            counter_nxt = latch_nxt;
        else if (wr_thi && !start)
            counter_nxt = latch_nxt;
        else if (tick)
            counter_nxt = counter - 16'd1;
    end

    // A control write overrides the one-shot clear from a coincident underflow.
    always_comb begin
        start_nxt = start;
        if (underflow && runmode)
            start_nxt = 1'b0;
        if (wr_thi && !start && runmode)
            start_nxt = 1'b1;
        if (wr_tcr)
            start_nxt = bus.data_in[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch      <= 16'hFFFF;
            counter    <= 16'hFFFF;
            start      <= 1'b0;
            runmode    <= 1'b0;
            inmode     <= 1'b0;
            spmode_bit <= 1'b0;
            tmr_ovf    <= 1'b0;
        end else if (clk7_en) begin
            latch   <= latch_nxt;
            counter <= counter_nxt;
            start   <= start_nxt;
            tmr_ovf <= underflow;
            if (wr_tcr) begin
                runmode    <= bus.data_in[3];
                inmode     <= bus.data_in[5];
                spmode_bit <= bus.data_in[6];
            end
        end
    end

    always_comb begin
        bus.data_out = 8'h00;
        if (!bus.wr) begin
            if (bus.tlo)
                bus.data_out = counter[7:0];
            else if (bus.thi)
                bus.data_out = counter[15:8];
            else if (bus.tcr)
                bus.data_out = {1'b0, spmode_bit, inmode, 1'b0, runmode, 2'b00, start};
        end
    end

    assign spmode = spmode_bit;

endmodule

// File: tb/tb_cia_timer_a.sv
// Directed bench for cia_timer_a: expected values queued, then popped and checked against DUT reads.
module tb_cia_timer_a;

    logic clk;
    logic reset_n;
    logic clk7_en;
    logic eclk;
    logic tmr_ovf;
    logic spmode;

    cia_timer_a_if bus ();

    cia_timer_a dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk7_en (clk7_en),
        .eclk    (eclk),
        .bus     (bus.slave),
        .tmr_ovf (tmr_ovf),
        .spmode  (spmode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb [$];

    // Advance n clock edges; inputs change and outputs are sampled 1 ns after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] e);
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic wr_reg(input logic [2:0] sel, input logic [7:0] d);
        bus.wr      = 1'b1;
        bus.tlo     = sel[0];
        bus.thi     = sel[1];
        bus.tcr     = sel[2];
        bus.data_in = d;
        step(1);
        bus.wr      = 1'b0;
        bus.tlo     = 1'b0;
        bus.thi     = 1'b0;
        bus.tcr     = 1'b0;
        bus.data_in = 8'h00;
    endtask

    task automatic rd_cnt(output logic [15:0] v);
        bus.wr = 1'b0;
        bus.tlo = 1'b1; bus.thi = 1'b0; bus.tcr = 1'b0;
        #1 v[7:0] = bus.data_out;
        bus.tlo = 1'b0; bus.thi = 1'b1;
        #1 v[15:8] = bus.data_out;
        bus.thi = 1'b0;
    endtask

    task automatic rd_cr(output logic [7:0] v);
        bus.wr = 1'b0;
        bus.tcr = 1'b1; bus.tlo = 1'b0; bus.thi = 1'b0;
        #1 v = bus.data_out;
        bus.tcr = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] e);
        logic [15:0] v;
        push(e);
        rd_cnt(v);
        cmp(tag, v);
    endtask

    task automatic chk_cr(input string tag, input logic [7:0] e);
        logic [7:0] v;
        push({8'h00, e});
        rd_cr(v);
        cmp(tag, {8'h00, v});
    endtask

    task automatic chk_ovf(input string tag, input logic e);
        push({15'd0, e});
        cmp(tag, {15'd0, tmr_ovf});
    endtask

    localparam logic [2:0] S_TLO = 3'b001;
    localparam logic [2:0] S_THI = 3'b010;
    localparam logic [2:0] S_TCR = 3'b100;

    logic [15:0] cont_cnt [6];
    logic        cont_ovf [6];

    initial begin
        cont_cnt = '{16'h0001, 16'h0000, 16'h0002, 16'h0001, 16'h0000, 16'h0002};
        cont_ovf = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0;
        clk7_en = 1'b1;
        eclk    = 1'b0;
        bus.wr = 1'b0; bus.tlo = 1'b0; bus.thi = 1'b0; bus.tcr = 1'b0;
        bus.data_in = 8'h00;

        // Reset state
        step(2);
        chk_cnt("rst_cnt", 16'hFFFF);
        chk_cr("rst_cr", 8'h00);
        chk_ovf("rst_ovf", 1'b0);
        reset_n = 1'b1;
        step(1);
        begin
            logic [7:0] v;
            push(16'h0000);
            bus.wr = 1'b0; bus.tlo = 1'b0; bus.thi = 1'b0; bus.tcr = 1'b0;
            #1 v = bus.data_out;
            cmp("no_sel_read", {8'h00, v});
        end

        // Continuous mode, latch = 2
        wr_reg(S_TLO, 8'h02);
        wr_reg(S_THI, 8'h00);
        chk_cnt("thi_load_stopped", 16'h0002);
        wr_reg(S_TCR, 8'h01);
        chk_cr("cr_start", 8'h01);
        eclk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk_cnt($sformatf("cont_cnt_%0d", i), cont_cnt[i]);
            chk_ovf($sformatf("cont_ovf_%0d", i), cont_ovf[i]);
        end

        // One-shot: single pulse, START cleared, counter holds latch
        eclk = 1'b0;
        wr_reg(S_TCR, 8'h09);
        eclk = 1'b1;
        step(3);
        chk_ovf("os_ovf", 1'b1);
        chk_cnt("os_reload", 16'h0002);
        step(2);
        chk_ovf("os_ovf_gone", 1'b0);
        chk_cnt("os_hold", 16'h0002);
        chk_cr("os_cr", 8'h08);

        // One-shot auto-start from high-byte write
        eclk = 1'b0;
        wr_reg(S_TLO, 8'h01);
        wr_reg(S_THI, 8'h00);
        chk_cnt("autostart_cnt", 16'h0001);
        chk_cr("autostart_cr", 8'h09);
        eclk = 1'b1;
        step(1);
        chk_cnt("autostart_t1", 16'h0000);
        chk_ovf("autostart_ovf0", 1'b0);
        step(1);
        chk_ovf("autostart_ovf1", 1'b1);
        chk_cr("autostart_stop", 8'h08);

        // Force load mid-count gives no pulse
        eclk = 1'b0;
        wr_reg(S_TCR, 8'h00);
        wr_reg(S_TLO, 8'h10);
        wr_reg(S_THI, 8'h00);
        wr_reg(S_TCR, 8'h01);
        eclk = 1'b1;
        step(3);
        chk_cnt("mid_count", 16'h000D);
        wr_reg(S_TCR, 8'h11);
        chk_cnt("force_load", 16'h0010);
        chk_ovf("force_load_ovf", 1'b0);
        chk_cr("force_not_stored", 8'h01);

        // High-byte write while running touches latch only
        eclk = 1'b0;
        wr_reg(S_TLO, 8'h20);
        wr_reg(S_THI, 8'h00);
        chk_cnt("thi_running", 16'h0010);

        // Clock enable low: neither ticks nor writes land
        clk7_en = 1'b0;
        eclk = 1'b1;
        wr_reg(S_TCR, 8'h00);
        step(3);
        chk_cnt("cen_off_cnt", 16'h0010);
        chk_cr("cen_off_cr", 8'h01);
        clk7_en = 1'b1;
        eclk = 1'b0;

        // Latch zero, continuous: underflow every tick
        wr_reg(S_TCR, 8'h00);
        wr_reg(S_TLO, 8'h00);
        wr_reg(S_THI, 8'h00);
        chk_cnt("zero_load", 16'h0000);
        wr_reg(S_TCR, 8'h01);
        eclk = 1'b1;
        step(1);
        chk_ovf("zero_ovf1", 1'b1);
        chk_cnt("zero_cnt1", 16'h0000);
        step(1);
        chk_ovf("zero_ovf2", 1'b1);

        // Control write coincident with one-shot underflow: written START wins
        eclk = 1'b0;
        wr_reg(S_TCR, 8'h09);
        eclk = 1'b1;
        wr_reg(S_TCR, 8'h49);
        eclk = 1'b0;
        chk_ovf("tcr_coinc_ovf", 1'b1);
        chk_cr("tcr_coinc_cr", 8'h49);
        push(16'h0001);
        cmp("spmode", {15'd0, spmode});

        // High-byte write coincident with underflow: reload sees new latch
        wr_reg(S_TCR, 8'h01);
        wr_reg(S_TLO, 8'h05);
        eclk = 1'b1;
        wr_reg(S_THI, 8'h01);
        chk_cnt("thi_coinc_cnt", 16'h0105);
        chk_ovf("thi_coinc_ovf", 1'b1);

        // Asynchronous reset between edges while counting
        #2 reset_n = 1'b0;
        #1;
        chk_ovf("arst_ovf", 1'b0);
        chk_cnt("arst_cnt", 16'hFFFF);
        chk_cr("arst_cr", 8'h00);
        step(1);
        reset_n = 1'b1;
        step(3);
        chk_cnt("post_rst_idle", 16'hFFFF);
        chk_ovf("post_rst_ovf", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
